// File: rtl/reg_bank_arb_pkg.sv
// Shared types and sizing helpers for the round-robin register bank arbiter.
// The state encoding is used only when REG_ARB_LOCK_EN is defined.
package reg_bank_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Ceiling log2, never below 1 so that every index field has at least one bit.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int cw_f(input int lock_max);
        return clog2_f(lock_max + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first request at or
// above ptr, wrapping at NREQ-1; idx is the binary index of that grant.
module rr_pick
    import reg_bank_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int PW = clog2_f(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    always_comb begin
        int j;
        logic found;
        j     = 0;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbitrated write access from NREQ requesters to a bank of DEPTH
// initialised registers, with a one-entry write stage and a registered read port.
// Define REG_ARB_LOCK_EN to add a bounded lock (LOCKED state) for one owner.
module reg_bank_arbiter
    import reg_bank_arb_pkg::*;
#(
    parameter int               width    = 32,
    parameter int               NREQ     = 4,
    parameter int               DEPTH    = 8,
    parameter logic [width-1:0] init     = {width{1'b0}},
    parameter int               LOCK_MAX = 16,
    localparam int              AW       = clog2_f(DEPTH),
    localparam int              PW       = clog2_f(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*AW-1:0]    ADDR,
    input  logic [NREQ*width-1:0] DATA,
    input  logic [NREQ-1:0]       LOCK,
    output logic [NREQ-1:0]       GNT,
    input  logic [AW-1:0]         RD_ADDR,
    output logic [width-1:0]      RD_DATA,
    output logic                  BUSY
);

    logic [NREQ-1:0]  pick_gnt;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [PW-1:0]    gnt_idx;
    logic             grant;

    logic             vld_p1;
    logic [AW-1:0]    addr_p1;
    logic [width-1:0] data_p1;
    logic             in_range;

    logic [width-1:0] bank [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] k);
        return (int'(k) == NREQ - 1) ? '0 : k + 1'b1;
    endfunction

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (REQ),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

`ifdef REG_ARB_LOCK_EN
    localparam int CW = cw_f(LOCK_MAX);

    arb_state_e    state, state_nxt;
    logic [PW-1:0] owner, owner_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
`else
    logic unused_lock;
    assign unused_lock = (^LOCK) ^ (LOCK_MAX > 0);
`endif

    always_comb begin
        GNT     = '0;
        gnt_idx = pick_idx;
        ptr_nxt = ptr;
`ifdef REG_ARB_LOCK_EN
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
`endif
        if (!RST) begin
`ifdef REG_ARB_LOCK_EN
            if (state == LOCKED) begin
                gnt_idx = owner;
                if (REQ[owner]) begin
                    GNT[owner] = 1'b1;
                    cnt_nxt    = cnt + 1'b1;
                    // The releasing grant (LOCK dropped or LOCK_MAX-th) is still issued.
                    if (!LOCK[owner] || cnt == CW'(LOCK_MAX - 1)) begin
                        state_nxt = IDLE;
                        ptr_nxt   = ptr_inc(owner);
                    end
                end else begin
                    state_nxt = IDLE;
                    ptr_nxt   = ptr_inc(owner);
                end
            end else
`endif
            begin
                GNT = pick_gnt;
                if (|pick_gnt) begin
                    ptr_nxt = ptr_inc(pick_idx);
`ifdef REG_ARB_LOCK_EN
                    if (LOCK[pick_idx] && LOCK_MAX > 1) begin
                        state_nxt = LOCKED;
                        owner_nxt = pick_idx;
                        cnt_nxt   = CW'(1);
                    end
`endif
                end
            end
        end
    end

    assign grant = |GNT;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= '0;
`ifdef REG_ARB_LOCK_EN
            state <= IDLE;
            owner <= '0;
            cnt   <= '0;
`endif
        end else begin
            ptr <= ptr_nxt;
`ifdef REG_ARB_LOCK_EN
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
`endif
        end
    end

    // p1: write stage, captured on the grant edge
    always_ff @(posedge CLK) begin
        if (RST) vld_p1 <= 1'b0;
        else     vld_p1 <= grant;
        if (grant) begin
            addr_p1 <= ADDR[int'(gnt_idx)*AW +: AW];
            data_p1 <= DATA[int'(gnt_idx)*width +: width];
        end
    end

    assign in_range = (int'(addr_p1) < DEPTH);
    assign BUSY     = vld_p1;

    // p2: bank commit and registered read (no forwarding of the same-edge commit)
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= init;
            RD_DATA <= init;
        end else begin
            if (vld_p1) assert (in_range);
            if (vld_p1 && in_range) bank[addr_p1] <= data_p1;
            RD_DATA <= bank[RD_ADDR];
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, round-robin order, write latency,
// read without forwarding, back-to-back same-index writes, reset discard, and lock.
module tb_reg_bank_arbiter;

    localparam int               W    = 32;
    localparam int               N    = 4;
    localparam int               D    = 8;
    localparam int               AW   = 3;
    localparam logic [W-1:0]     INIT = 32'hA5A5_0000;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N*W-1:0]  data;
    logic [N-1:0]    lock;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rd_addr;
    logic [W-1:0]    rd_data;
    logic            busy;

    int checks;
    int errors;

    reg_bank_arbiter #(
        .width(W), .NREQ(N), .DEPTH(D), .init(INIT), .LOCK_MAX(16)
    ) dut (
        .CLK(clk), .RST(rst), .REQ(req), .ADDR(addr), .DATA(data), .LOCK(lock),
        .GNT(gnt), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
        addr[i*AW +: AW] = a;
        data[i*W +: W]   = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; lock = '0; rd_addr = '0;
        addr = '0; data = '0;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt0 got=%b want=0000", gnt); end
        tick();
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt1 got=%b want=0000", gnt); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (rd_data !== INIT) begin errors++; $display("FAIL reset_rd got=%h want=%h", rd_data, INIT); end
        tick();
        rst = 1'b0; req = '0;
        for (int i = 0; i < D; i++) begin
            rd_addr = AW'(i);
            tick();
            checks++;
            if (rd_data !== INIT) begin errors++; $display("FAIL reset_bank[%0d] got=%h want=%h", i, rd_data, INIT); end
        end
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            errors++; $display("FAIL idle_after_reset busy=%b gnt=%b want 0/0000", busy, gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [8];
        logic [W-1:0] exp_d [4];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_d = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003};
        for (int i = 0; i < N; i++) set_req(i, AW'(i), exp_d[i]);
        rd_addr = 3'd0;
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (gnt !== exp_g[c]) begin errors++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, gnt, exp_g[c]); end
            tick();
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy c=%0d got=%b want=1", c, busy); end
            if (c < 2) begin
                checks++;
                if (rd_data !== INIT) begin errors++; $display("FAIL rr_latency c=%0d got=%h want=%h", c, rd_data, INIT); end
            end else if (c == 2) begin
                checks++;
                if (rd_data !== exp_d[0]) begin errors++; $display("FAIL rr_commit0 got=%h want=%h", rd_data, exp_d[0]); end
            end
        end
        req = '0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy_end got=%b want=0", busy); end
        for (int i = 1; i < N; i++) begin
            rd_addr = AW'(i);
            tick();
            checks++;
            if (rd_data !== exp_d[i]) begin errors++; $display("FAIL rr_bank[%0d] got=%h want=%h", i, rd_data, exp_d[i]); end
        end
    endtask

    task automatic test_no_forward();
        set_req(2, 3'd5, 32'hDEAD_BEEF);
        req = 4'b0100;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL nf_gnt got=%b want=0100", gnt); end
        tick();
        req = '0;
        rd_addr = 3'd5;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL nf_gnt_idle got=%b want=0000", gnt); end
        tick();
        checks++;
        if (rd_data !== INIT) begin errors++; $display("FAIL nf_old got=%h want=%h", rd_data, INIT); end
        tick();
        checks++;
        if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nf_new got=%h want=deadbeef", rd_data); end
    endtask

    task automatic test_back_to_back();
        set_req(1, 3'd6, 32'h1);
        set_req(3, 3'd6, 32'h3);
        req = 4'b0010;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL b2b_gnt1 got=%b want=0010", gnt); end
        tick();
        req = 4'b1000;
        #1;
        checks++;
        if (gnt !== 4'b1000) begin errors++; $display("FAIL b2b_gnt3 got=%b want=1000", gnt); end
        tick();
        req = '0;
        rd_addr = 3'd6;
        tick();
        checks++;
        if (rd_data !== 32'h1) begin errors++; $display("FAIL b2b_first got=%h want=1", rd_data); end
        tick();
        checks++;
        if (rd_data !== 32'h3) begin errors++; $display("FAIL b2b_last got=%h want=3", rd_data); end

        req = 4'b0010;
        tick();
        req = 4'b1000;
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_pre got=%b want=1", busy); end
        rst = 1'b1;
        req = 4'b1111;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL b2b_rst_gnt got=%b want=0000", gnt); end
        tick();
        req = '0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_rst_busy got=%b want=0", busy); end
        rst = 1'b0;
        tick();
        checks++;
        if (rd_data !== INIT) begin errors++; $display("FAIL b2b_rst_bank got=%h want=%h", rd_data, INIT); end
        tick();
        checks++;
        if (rd_data !== INIT) begin errors++; $display("FAIL b2b_discard got=%h want=%h", rd_data, INIT); end
    endtask

    task automatic test_lock();
        logic [N-1:0] exp_g;
        rst = 1'b1; req = '0; lock = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, AW'(i), W'(i));
        req = 4'b1111;
        lock = 4'b0001;
`ifdef REG_ARB_LOCK_EN
        for (int c = 0; c < 17; c++) begin
            exp_g = (c < 16) ? 4'b0001 : 4'b0010;
`else
        for (int c = 0; c < 6; c++) begin
            exp_g = 4'b0001 << (c % 4);
`endif
            #1;
            checks++;
            if (gnt !== exp_g) begin errors++; $display("FAIL lock_max c=%0d got=%b want=%b", c, gnt, exp_g); end
            tick();
        end

        req = '0; lock = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            lock = (c < 2) ? 4'b0001 : 4'b0000;
`ifdef REG_ARB_LOCK_EN
            exp_g = (c < 3) ? 4'b0001 : (4'b0001 << (c - 2));
`else
            exp_g = 4'b0001 << (c % 4);
`endif
            #1;
            checks++;
            if (gnt !== exp_g) begin errors++; $display("FAIL lock_drop c=%0d got=%b want=%b", c, gnt, exp_g); end
            tick();
        end
        req = '0; lock = '0;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL lock_noreq got=%b want=0000", gnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_round_robin();
        test_no_forward();
        test_back_to_back();
        test_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares a bank of DEPTH enabled, initialised registers between NREQ write requesters using round-robin arbitration.
- Provides one registered read port.
- Sits between multiple Bluespec rule/method callers and a common configuration/status register bank, replacing per-caller muxing of D_IN/EN.

Parameters:
- width, 32, data width of each bank register
- NREQ, 4, number of write requesters (2..8)
- DEPTH, 8, number of registers in bank (power of two, 2..64)
- init, {width{1'b0}}, reset value loaded into every bank register
- LOCK_MAX, 16, maximum consecutive grants to a locked owner (only with lock feature)

Ports:
- CLK  in  1  clock, all state on posedge
- RST  in  1  synchronous reset, active-high
- REQ  in  NREQ  per-requester write request
- ADDR  in  NREQ*AW  per-requester register index, AW=clog2(DEPTH); requester i uses slice [i*AW +: AW]
- DATA  in  NREQ*width  per-requester write data; slice [i*width +: width]
- LOCK  in  NREQ  per-requester lock request (ignored unless REG_ARB_LOCK_EN)
- GNT  out  NREQ  one-hot grant, combinational, same cycle as REQ
- RD_ADDR  in  AW  read index
- RD_DATA  out  width  registered read data
- BUSY  out  1  write stage holds an uncommitted write

Behaviour:
- Reset (RST=1 at posedge): every bank entry = init; RR pointer = 0; write stage invalid; state IDLE; lock counter = 0; RD_DATA = init; BUSY = 0. GNT is 0 during any cycle with RST=1.
- Arbitration, state IDLE:
  - GNT selects the first asserted REQ searching from index ptr upward, wrapping at NREQ-1 to 0.
  - GNT = 0 when REQ = 0.
  - At most one GNT bit is set.
  - On a grant to requester k, ptr <= (k+1) mod NREQ; ptr is unchanged when no grant is issued.
- A grant is the handshake: requester k's ADDR/DATA slice is captured into the write stage on that edge. A requester holds REQ until it sees GNT. Deasserting REQ without GNT is legal and drops the request.
- Write stage: captured write commits to bank[addr] on the next edge. Write-to-bank latency is 2 edges from the grant cycle. BUSY = stage valid.
- A grant is allowed every cycle. The stage is a pipeline register, never a stall.
- Out-of-range address (ADDR >= DEPTH; possible only if DEPTH is not a power of two, so it is asserted impossible): the write is dropped.
- Read:
  - RD_DATA <= bank[RD_ADDR] every edge; 1-cycle latency.
  - No forwarding: if a commit to the same index occurs on the same edge, RD_DATA returns the old value. The new value appears on the following read.
- Two consecutive grants to the same index: both commit in order; the last one wins.
- Reset asserted while the stage is valid: the staged write is discarded.

Optional Feature:
- Macro: REG_ARB_LOCK_EN.
- Enabled: adds state LOCKED with an owner register and a grant counter.
  - IDLE->LOCKED when the granted requester k has LOCK[k]=1. Owner = k, counter = 1.
  - In LOCKED, GNT = one-hot(owner) if REQ[owner], else 0. Other requesters are starved. Each grant increments the counter.
  - LOCKED->IDLE on any of: a grant with LOCK[owner]=0 (that grant is still issued); REQ[owner]=0; counter reaching LOCK_MAX (the LOCK_MAX-th grant is issued, then the lock is released).
  - ptr <= (owner+1) mod NREQ on exit.
- Disabled: LOCK is ignored, no LOCKED state, no owner/counter registers are synthesised.

Decomposition:
- Package reg_bank_arb_pkg:
  - state encoding IDLE=0, LOCKED=1
  - AW = clog2(DEPTH) function
  - counter width CW = clog2(LOCK_MAX+1)
- One sub-module, rr_pick: combinational round-robin one-hot picker with inputs req[NREQ] and ptr, outputs gnt and idx. It is reused by other arbiters.
- The bank, write stage and FSM live in the top module.

Test Plan:
- Reset then read all 8 indices with init=32'hA5A5_0000 -> RD_DATA = 32'hA5A5_0000 one cycle after each RD_ADDR. GNT=0 and BUSY=0 throughout reset.
- REQ=4'b1111 held for 8 cycles, each requester writing its own index -> GNT sequence 0001,0010,0100,1000, repeating. Bank[0..3] hold each requester's data 2 edges after its grant.
- Requester 2 writes 32'hDEAD_BEEF to index 5 while RD_ADDR=5 on the commit edge -> RD_DATA shows the old value, then 32'hDEAD_BEEF on the next cycle.
- Requesters 1 and 3 write index 6 with 32'h1 and 32'h3 in back-to-back grants -> bank[6]=32'h3. RST pulsed one cycle after the second grant -> bank[6]=init, BUSY=0.
- With REG_ARB_LOCK_EN: requester 0 holds LOCK=1 and REQ=1, others request -> 16 consecutive grants to requester 0, then GNT=0010. With LOCK dropped after 3 grants -> lock released after the 3rd grant.
- Without REG_ARB_LOCK_EN, same stimulus -> strict round-robin; LOCK has no effect.
